// File: rtl/pe_seq_pkg.sv
// rtl/pe_seq_pkg.sv - shared types and defaults for the PE accumulation sequencer
//
// Purpose: state encoding, PE latency default and the lane-vector type shared
//          by the sequencer and anything that talks to it.
// Ports:   none (package).

package pe_seq_pkg;

    localparam int REG_WIDTH_DEF = 16;
    localparam int VECTOR_DEF    = 8;
    localparam int PE_LAT_DEF    = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } seq_state_e;

    typedef logic [REG_WIDTH_DEF-1:0] lane_vec_t [VECTOR_DEF];

endpackage

// File: rtl/pe_accum_sequencer.sv
// rtl/pe_accum_sequencer.sv - drives an external vector MAC PE through a K-step accumulation
//
// Purpose: accepts a job (start + k_len), streams k_len operand beats into the
//          PE, feeds the PE output back into its c input, then captures the
//          final vector and offers it on a valid/ready result port.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, k_len, busy  job request / beat count / job in flight
//   op_valid, op_ready  operand beat handshake; op_a per lane, op_b scalar
//   pe_a, pe_b, pe_c    drive to the PE inputs
//   pe_c_ab             PE registered result
//   res_valid, res_ready, res_data  result handshake and vector
//   done                one-cycle pulse after the result handshake

module pe_accum_sequencer
    import pe_seq_pkg::*;
#(
    parameter int REG_WIDTH = 16,
    parameter int VECTOR    = 8,
    parameter int KW        = 8,
    parameter int PE_LAT    = PE_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    output logic                 busy,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [REG_WIDTH-1:0] op_a [VECTOR],
    input  logic [REG_WIDTH-1:0] op_b,
    output logic [REG_WIDTH-1:0] pe_a [VECTOR],
    output logic [REG_WIDTH-1:0] pe_b [VECTOR],
    output logic [REG_WIDTH-1:0] pe_c [VECTOR],
    input  logic [REG_WIDTH-1:0] pe_c_ab [VECTOR],
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [REG_WIDTH-1:0] res_data [VECTOR],
    output logic                 done
);

    localparam int            DW         = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PE_LAT - 1);
    localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);
    localparam logic [KW-1:0] BEAT_ONE   = KW'(1);

    seq_state_e           state_q;
    logic [KW-1:0]        k_len_q;
    logic [KW-1:0]        beat_cnt_q;
    logic [DW-1:0]        drain_cnt_q;
    logic                 busy_q;
    logic                 op_ready_q;
    logic                 res_valid_q;
    logic                 done_q;
    logic [REG_WIDTH-1:0] res_data_q [VECTOR];

    logic                 beat_acc;
    logic                 first_beat;
    logic [KW-1:0]        beat_cnt_nxt;

    assign beat_acc     = (state_q == RUN) && op_valid && op_ready_q;
    assign first_beat   = (beat_cnt_q == '0);
    assign beat_cnt_nxt = beat_cnt_q + BEAT_ONE;

    // Outside an accepted beat the PE sees a=0, b=0, c=c_ab, so it holds its value.
    // The first beat of a job seeds c with zero so no earlier job leaks in.
    always_comb begin
        for (int i = 0; i < VECTOR; i++) begin
            pe_a[i] = '0;
            pe_b[i] = '0;
            pe_c[i] = pe_c_ab[i];
            if (beat_acc) begin
                pe_a[i] = op_a[i];
                pe_b[i] = op_b;
                pe_c[i] = first_beat ? '0 : pe_c_ab[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            res_data_q  <= '{default: '0};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        k_len_q     <= k_len;
                        beat_cnt_q  <= '0;
                        drain_cnt_q <= '0;
                        busy_q      <= 1'b1;
                        if (k_len == '0) begin
                            res_data_q  <= '{default: '0};
                            res_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end else begin
                            op_ready_q <= 1'b1;
                            state_q    <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (beat_acc) begin
                        beat_cnt_q <= beat_cnt_nxt;
                        if (beat_cnt_nxt == k_len_q) begin
                            op_ready_q  <= 1'b0;
                            drain_cnt_q <= '0;
                            state_q     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Wait for the last beat to emerge from the PE pipeline.
                    if (drain_cnt_q == DRAIN_LAST) begin
                        res_data_q  <= pe_c_ab;
                        res_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DRAIN_ONE;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign op_ready  = op_ready_q;
    assign res_valid = res_valid_q;
    assign done      = done_q;
    assign res_data  = res_data_q;

endmodule
